// File: rtl/io_timer_pkg.sv
// Shared timer-bus definitions for the capture/compare FIFOs: timer select,
// output-compare actions, compare FSM states and the timer match helper.
package io_timer_pkg;

  localparam int unsigned TMR_W = 16;
  localparam int unsigned CMP_W = 2 * TMR_W;

  localparam logic [1:0] TMR_OFF = 2'd0;
  localparam logic [1:0] TMR0    = 2'd1;
  localparam logic [1:0] TMR1    = 2'd2;
  localparam logic [1:0] TMR32   = 2'd3;

  localparam logic [1:0] OC_TOGGLE = 2'd0;
  localparam logic [1:0] OC_SET    = 2'd1;
  localparam logic [1:0] OC_CLEAR  = 2'd2;
  localparam logic [1:0] OC_PULSE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2
  } oc_state_e;

  // Upper compare half only participates in the concatenated 32-bit mode.
  function automatic logic oc_hit(input logic [1:0] sel, input logic [CMP_W-1:0] cmp,
                                  input logic [TMR_W-1:0] t0, input logic [TMR_W-1:0] t1);
    logic hit;
    hit = 1'b0;
    case (sel)
      TMR0:    hit = (t0 == cmp[TMR_W-1:0]);
      TMR1:    hit = (t1 == cmp[TMR_W-1:0]);
      TMR32:   hit = ({t1, t0} == cmp);
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/oc_fifo_mem.sv
// Circular compare-value buffer with registered empty / not-full flags.
// Fullness for write acceptance is judged on the pre-edge count.
module oc_fifo_mem #(
  parameter int unsigned DEPTH = 20,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr,
  input  logic          i_rd,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata_c,
  output logic          o_empty,
  output logic          o_nfull
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          w_wr_ok;
  logic          w_rd_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_wr_ok     = i_wr && (r_count != CW'(DEPTH));
  assign w_rd_ok     = i_rd && (r_count != '0);
  assign w_count_nxt = r_count + CW'(w_wr_ok) - CW'(w_rd_ok);
  assign o_rdata_c   = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      o_empty  <= 1'b1;
      o_nfull  <= 1'b1;
    end else begin
      if (w_wr_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd_ok) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= w_count_nxt;
      o_empty <= (w_count_nxt == '0);
      o_nfull <= (w_count_nxt != CW'(DEPTH));
    end
  end

  // Storage carries no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/output_compare_fifo.sv
// Output-compare unit: queued compare values drive `outs` on timer match.
// Optional OC_IRQ_EN adds a one-cycle `oc_irq` pulse per match.
module output_compare_fifo
  import io_timer_pkg::*;
#(
  parameter int unsigned FIFO_LENGTH = 20,
  parameter logic        OUT_INIT    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       OCTMR,
  input  logic [1:0]       OCM,
  input  logic [TMR_W-1:0] t_val_bi_0,
  input  logic [TMR_W-1:0] t_val_bi_1,
  input  logic             wr_i,
  input  logic [CMP_W-1:0] OCBUF,
  output logic             outs,
  output logic             OCBE,
  output logic             OCBNF,
  output logic             OCOV,
  output logic             busy
`ifdef OC_IRQ_EN
  ,
  output logic             oc_irq
`endif
);

  oc_state_e        r_state;
  oc_state_e        w_state_nxt;
  logic [CMP_W-1:0] r_cmp;
  logic [CMP_W-1:0] w_rdata;
  logic             r_pulse;
  logic             w_pop;
  logic             w_match;
  logic             w_outs_nxt;
  logic             w_pulse_nxt;
  logic             w_ocov_nxt;

  oc_fifo_mem #(
    .DEPTH (FIFO_LENGTH),
    .DW    (CMP_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr      (wr_i),
    .i_rd      (w_pop),
    .i_wdata   (OCBUF),
    .o_rdata_c (w_rdata),
    .o_empty   (OCBE),
    .o_nfull   (OCBNF)
  );

  // Next state, pop request and pin action.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_match     = 1'b0;
    w_outs_nxt  = r_pulse ? 1'b0 : outs;
    w_pulse_nxt = 1'b0;
    w_ocov_nxt  = OCOV;

    if (OCTMR == TMR_OFF) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (!OCBE) w_state_nxt = ST_LOAD;
        ST_LOAD: begin
          w_pop       = 1'b1;
          w_state_nxt = ST_ARMED;
        end
        ST_ARMED: if (oc_hit(OCTMR, r_cmp, t_val_bi_0, t_val_bi_1)) begin
          w_match     = 1'b1;
          w_state_nxt = OCBE ? ST_IDLE : ST_LOAD;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    if (w_match) begin
      case (OCM)
        OC_TOGGLE: w_outs_nxt = ~outs;
        OC_SET:    w_outs_nxt = 1'b1;
        OC_CLEAR:  w_outs_nxt = 1'b0;
        OC_PULSE: begin
          w_outs_nxt  = 1'b1;
          w_pulse_nxt = 1'b1;
        end
      endcase
    end

    if (wr_i && !OCBNF)                  w_ocov_nxt = 1'b1;
    else if (OCTMR == TMR_OFF && !wr_i)  w_ocov_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cmp   <= '0;
      r_pulse <= 1'b0;
      outs    <= OUT_INIT;
      OCOV    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) r_cmp <= w_rdata;
      r_pulse <= w_pulse_nxt;
      outs    <= w_outs_nxt;
      OCOV    <= w_ocov_nxt;
      busy    <= (w_state_nxt == ST_ARMED);
    end
  end

`ifdef OC_IRQ_EN
  // A match that drains the last entry is also the empty event: one pulse covers both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) oc_irq <= 1'b0;
    else     oc_irq <= w_match;
  end
`endif

endmodule
